// File: rtl/regfile_ext_pkg.sv
// Shared CPU package: register index names, default datapath width and the
// byte-merge helper shared by the register file and the memory interface.
package regfile_ext_pkg;

  localparam int unsigned CPU_WIDTH = 16;
  // Widest datapath byte_merge supports; callers zero-extend and truncate.
  localparam int unsigned MAX_W     = 64;
  localparam int unsigned MAX_BE    = MAX_W / 8;

  typedef enum logic [2:0] {R0, R1, R2, R3, R4, R5, R6, R7} reg_idx_e;
  localparam reg_idx_e SP = R7;

  // Per-byte select: a byte takes new_v where be is set, else keeps old_v.
  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0]  old_v,
                                                  input logic [MAX_W-1:0]  new_v,
                                                  input logic [MAX_BE-1:0] be);
    logic [MAX_W-1:0] merged;
    merged = old_v;
    for (int i = 0; i < int'(MAX_BE); i++) begin
      if (be[i]) merged[8*i +: 8] = new_v[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/regfile_ext_if.sv
// Register-file bus: read selects/enable, write port with byte enables,
// adjust port, and the registered results.
//   master: decoder/control side (drives selects, enables, write data)
//   slave : register file side (drives src, dst, adj_val, adj_wrap)
interface regfile_ext_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8
);

  localparam int unsigned SEL_W = $clog2(NREGS);

  logic [SEL_W-1:0]   src_sel;
  logic [SEL_W-1:0]   dst_sel;
  logic               out_en;
  logic [WIDTH-1:0]   src;
  logic [WIDTH-1:0]   dst;
  logic               in_en;
  logic [WIDTH/8-1:0] in_be;
  logic [WIDTH-1:0]   in;
  logic               adj_en;
  logic [SEL_W-1:0]   adj_sel;
  logic               adj_dec;
  logic [WIDTH-1:0]   adj_val;
  logic               adj_wrap;

  modport master (
    output src_sel, dst_sel, out_en, in_en, in_be, in, adj_en, adj_sel, adj_dec,
    input  src, dst, adj_val, adj_wrap
  );

  modport slave (
    input  src_sel, dst_sel, out_en, in_en, in_be, in, adj_en, adj_sel, adj_dec,
    output src, dst, adj_val, adj_wrap
  );

endinterface

// File: rtl/regfile_adjuster.sv
// Combinational +/- STEP unit with carry (add) or borrow (subtract) out.
//   val    : operand
//   dec    : 0 = add STEP, 1 = subtract STEP
//   res_c  : result modulo 2^WIDTH
//   wrap_c : carry out of bit WIDTH-1, or borrow
module regfile_adjuster #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 1
) (
  input  logic [WIDTH-1:0] val,
  input  logic             dec,
  output logic [WIDTH-1:0] res_c,
  output logic             wrap_c
);

  localparam int unsigned EW = WIDTH + 1;

  logic [EW-1:0] sum_c;
  logic [EW-1:0] diff_c;

  // One extra bit exposes the carry; a borrow sets it via two's complement.
  assign sum_c  = {1'b0, val} + EW'(STEP);
  assign diff_c = {1'b0, val} - EW'(STEP);

  assign res_c  = dec ? diff_c[WIDTH-1:0] : sum_c[WIDTH-1:0];
  assign wrap_c = dec ? diff_c[WIDTH]     : sum_c[WIDTH];

endmodule

// File: rtl/regfile_ext.sv
// Parametrised CPU register file: two registered read ports with write-first
// bypass, one byte-enabled write port and an increment/decrement port.
//   clk, rst : clock, synchronous active-high reset
//   bus      : regfile_ext_if slave (selects, write data, adjust, results)
module regfile_ext
  import regfile_ext_pkg::*;
#(
  parameter int unsigned WIDTH    = CPU_WIDTH,
  parameter int unsigned NREGS    = 8,
  parameter int unsigned SEL_W    = $clog2(NREGS),
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned STEP     = 1
) (
  input logic          clk,
  input logic          rst,
  regfile_ext_if.slave bus
);

  logic [WIDTH-1:0] regs     [NREGS];
  logic [WIDTH-1:0] regs_nxt [NREGS];

  logic [WIDTH-1:0] src_q;
  logic [WIDTH-1:0] dst_q;
  logic [WIDTH-1:0] adj_val_q;
  logic             adj_wrap_q;

  logic [WIDTH-1:0] wr_val_c;
  logic [WIDTH-1:0] adj_res_c;
  logic             adj_carry_c;
  logic             collide_c;
  logic             adj_live_c;
  logic             adj_zero_c;
  logic             wrap_nxt_c;

  regfile_adjuster #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_adjuster (
    .val    (regs[bus.adj_sel]),
    .dec    (bus.adj_dec),
    .res_c  (adj_res_c),
    .wrap_c (adj_carry_c)
  );

  // Byte-merged write value for the write target.
  assign wr_val_c = WIDTH'(byte_merge(MAX_W'(regs[bus.dst_sel]), MAX_W'(bus.in),
                                      MAX_BE'(bus.in_be)));

  assign adj_zero_c = (ZERO_REG != 0) && (bus.adj_sel == SEL_W'(0));

  // Next-state array; read ports and adj_val are taken from it (write-first).
  always_comb begin
    regs_nxt   = regs;
    collide_c  = bus.in_en && bus.adj_en && (bus.dst_sel == bus.adj_sel);
    adj_live_c = bus.adj_en && !collide_c;
    if (bus.in_en)  regs_nxt[bus.dst_sel] = wr_val_c;
    if (adj_live_c) regs_nxt[bus.adj_sel] = adj_res_c;
    if (ZERO_REG != 0) regs_nxt[0] = '0;
    wrap_nxt_c = adj_live_c && adj_carry_c && !adj_zero_c;
  end

  // Storage and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs       <= '{default: '0};
      src_q      <= '0;
      dst_q      <= '0;
      adj_val_q  <= '0;
      adj_wrap_q <= 1'b0;
    end else begin
      regs <= regs_nxt;
      if (bus.out_en) begin
        src_q <= regs_nxt[bus.src_sel];
        dst_q <= regs_nxt[bus.dst_sel];
      end
      if (bus.adj_en) adj_val_q <= regs_nxt[bus.adj_sel];
      adj_wrap_q <= wrap_nxt_c;
    end
  end

  assign bus.src      = src_q;
  assign bus.dst      = dst_q;
  assign bus.adj_val  = adj_val_q;
  assign bus.adj_wrap = adj_wrap_q;

endmodule

// File: tb/tb_regfile_ext.sv
// Bench for regfile_ext: one instance with ZERO_REG=0 and one with ZERO_REG=1,
// driven identically; a reference model predicts outputs per edge into
// queues that a monitor drains and compares.
module tb_regfile_ext;
  import regfile_ext_pkg::*;

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] av;
    logic        aw;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [2:0]  src_sel, dst_sel, adj_sel;
  logic        out_en, in_en, adj_en, adj_dec;
  logic [1:0]  in_be;
  logic [15:0] din;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model state: [z] = 0 for the plain build, 1 for ZERO_REG build
  int unsigned mreg [2][8];
  int unsigned m_src[2], m_dst[2], m_av[2];
  bit          m_aw [2];

  regfile_ext_if #(.WIDTH(16), .NREGS(8)) bus0 ();
  regfile_ext_if #(.WIDTH(16), .NREGS(8)) bus1 ();

  regfile_ext #(.WIDTH(16), .NREGS(8), .ZERO_REG(0), .STEP(1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  regfile_ext #(.WIDTH(16), .NREGS(8), .ZERO_REG(1), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  assign bus0.src_sel = src_sel;  assign bus1.src_sel = src_sel;
  assign bus0.dst_sel = dst_sel;  assign bus1.dst_sel = dst_sel;
  assign bus0.out_en  = out_en;   assign bus1.out_en  = out_en;
  assign bus0.in_en   = in_en;    assign bus1.in_en   = in_en;
  assign bus0.in_be   = in_be;    assign bus1.in_be   = in_be;
  assign bus0.in      = din;      assign bus1.in      = din;
  assign bus0.adj_en  = adj_en;   assign bus1.adj_en  = adj_en;
  assign bus0.adj_sel = adj_sel;  assign bus1.adj_sel = adj_sel;
  assign bus0.adj_dec = adj_dec;  assign bus1.adj_dec = adj_dec;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs at the falling edge and predict the state after
  // the next rising edge for both builds.
  task automatic drive(input bit r, input int ss, input int ds, input bit oe,
                       input bit ie, input int be, input int d,
                       input bit ae, input int as, input bit ad);
    exp_t e;
    @(negedge clk);
    rst = r; src_sel = 3'(ss); dst_sel = 3'(ds); out_en = oe;
    in_en = ie; in_be = 2'(be); din = 16'(d);
    adj_en = ae; adj_sel = 3'(as); adj_dec = ad;
    for (int z = 0; z < 2; z++) begin
      int unsigned nxt[8];
      int unsigned v;
      bit wrapped;
      for (int i = 0; i < 8; i++) nxt[i] = mreg[z][i];
      wrapped = 1'b0;
      if (r) begin
        for (int i = 0; i < 8; i++) nxt[i] = 0;
        m_src[z] = 0; m_dst[z] = 0; m_av[z] = 0;
      end else begin
        if (ie && !(z == 1 && ds == 0)) begin
          v = nxt[ds];
          for (int b = 0; b < 2; b++)
            if (((be >> b) & 1) != 0)
              v = (v & ~(32'hFF << (8*b))) | (32'(d) & (32'hFF << (8*b)));
          nxt[ds] = v;
        end
        if (ae) begin
          if (ie && ds == as) m_av[z] = nxt[as];
          else if (z == 1 && as == 0) m_av[z] = 0;
          else if (ad) begin
            wrapped = (mreg[z][as] < 1);
            nxt[as] = (mreg[z][as] + 65536 - 1) % 65536;
            m_av[z] = nxt[as];
          end else begin
            wrapped = (mreg[z][as] + 1 > 65535);
            nxt[as] = (mreg[z][as] + 1) % 65536;
            m_av[z] = nxt[as];
          end
        end
        if (oe) begin
          m_src[z] = nxt[ss];
          m_dst[z] = nxt[ds];
        end
      end
      m_aw[z] = wrapped;
      for (int i = 0; i < 8; i++) mreg[z][i] = nxt[i];
      e.src = 16'(m_src[z]); e.dst = 16'(m_dst[z]);
      e.av = 16'(m_av[z]); e.aw = m_aw[z];
      if (z == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic wr(input int r, input int d, input int be);
    drive(0, 0, r, 0, 1, be, d, 0, 0, 0);
  endtask
  task automatic rd(input int s, input int d);
    drive(0, s, d, 1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic adj(input int r, input bit dec);
    drive(0, 0, 0, 0, 0, 0, 0, 1, r, dec);
  endtask

  // Monitor: outputs are compared 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("z0 src", bus0.src, e.src);
        chk("z0 dst", bus0.dst, e.dst);
        chk("z0 adj_val", bus0.adj_val, e.av);
        chk("z0 adj_wrap", 16'(bus0.adj_wrap), 16'(e.aw));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("z1 src", bus1.src, e.src);
        chk("z1 dst", bus1.dst, e.dst);
        chk("z1 adj_val", bus1.adj_val, e.av);
        chk("z1 adj_wrap", 16'(bus1.adj_wrap), 16'(e.aw));
      end
    end
  end

  initial begin
    int drain;
    rst = 1'b1; src_sel = '0; dst_sel = '0; out_en = 1'b0; in_en = 1'b0;
    in_be = '0; din = '0; adj_en = 1'b0; adj_sel = '0; adj_dec = 1'b0;
    for (int z = 0; z < 2; z++) for (int i = 0; i < 8; i++) mreg[z][i] = 0;

    // Reset and zero read
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rd(0, 1);
    // Write then read, then hold
    wr(2, 10, 3);
    wr(3, 20, 3);
    rd(2, 3);
    idle();
    // Byte enable with same-cycle bypass on both ports
    wr(4, 16'h1234, 3);
    drive(0, 4, 4, 1, 1, 1, 16'hABCD, 0, 0, 0);
    rd(4, 4);
    // Adjust wrap on the stack pointer
    wr(int'(SP), 0, 3);
    adj(int'(SP), 1);
    adj(int'(SP), 0);
    adj(int'(SP), 0);
    idle();
    // Collision: write wins; then different targets both apply
    wr(5, 100, 3);
    drive(0, 0, 5, 0, 1, 3, 7, 1, 5, 0);
    wr(6, 100, 3);
    drive(0, 0, 5, 0, 1, 3, 7, 1, 6, 0);
    rd(5, 6);
    // Register 0 handling: plain build stores it, ZERO_REG build ignores it
    wr(0, 55, 3);
    adj(0, 0);
    rd(0, 0);
    // Reset beats a same-cycle write
    drive(1, 0, 1, 1, 1, 3, 55, 1, 1, 0);
    rd(1, 1);
    // Word edges: 0xFFFF upward wraps, read during the adjust
    wr(3, 16'hFFFF, 3);
    drive(0, 3, 2, 1, 0, 0, 0, 1, 3, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 59) == 0),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0) ? 16'hFFFF : int'($urandom_range(0, 65535)),
            bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            bit'($urandom_range(0, 1)));
    end
    idle();

    drain = 0;
    while ((q0.size() > 0 || q1.size() > 0) && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    #2;
    checks++;
    if (q0.size() > 0 || q1.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d entries left, expected 0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_ext.md
Name: regfile_ext

Overview:
Parametrised successor to the CPU general-purpose register file. It provides:
- N registers of WIDTH bits.
- Two registered read ports (src/dst), with write-first bypass.
- One write port with byte enables.
- An independent increment/decrement port for stack-pointer and index updates.

It sits between the decoder/control unit and the ALU/bus, and is a drop-in superset of the existing src_sel/dst_sel/out_en/in_en interface.

Parameters:
WIDTH, 16, register width in bits; must be a multiple of 8
NREGS, 8, number of registers; power of two, >= 2
SEL_W, $clog2(NREGS), select width (derived; do not override)
ZERO_REG, 0, 1 = register 0 reads as zero and ignores all writes/adjusts
STEP, 1, magnitude of an increment/decrement on the adjust port

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
src_sel  in  SEL_W  source read select
dst_sel  in  SEL_W  destination read select, and the write target
out_en  in  1  capture both read ports into src/dst this cycle
src  out  WIDTH  registered source read data
dst  out  WIDTH  registered destination read data
in_en  in  1  write enable for register dst_sel
in_be  in  WIDTH/8  byte enables for the write; bit i covers in[8i+7:8i]
in  in  WIDTH  write data
adj_en  in  1  adjust register adj_sel by STEP
adj_sel  in  SEL_W  adjust target
adj_dec  in  1  0 = add STEP, 1 = subtract STEP
adj_val  out  WIDTH  post-adjust value of adj_sel, registered
adj_wrap  out  1  1-cycle pulse: the last adjust wrapped (overflow or underflow)

Behaviour:
- **Reset:** rst sampled high at a rising edge sets every register, src, dst and adj_val to 0, and clears adj_wrap.
  - Reset has priority over all enables in the same cycle.
  - Reset mid-operation discards that cycle's write and adjust.
- **Write:** with in_en=1, at the edge, each byte of reg[dst_sel] where in_be[i]=1 takes in[byte i]. Other bytes hold their value.
- **Adjust:** with adj_en=1, reg[adj_sel] <= reg[adj_sel] +/- STEP, computed modulo 2^WIDTH.
  - adj_wrap=1 for one cycle if the add carried out of bit WIDTH-1, or the subtract borrowed.
  - adj_val is updated on every adj_en with the post-adjust value, and holds otherwise.
- **Write/adjust collision:** if in_en=1, adj_en=1 and dst_sel==adj_sel, the write wins and the adjust is dropped.
  - adj_val takes the written (merged) value and adj_wrap=0.
  - With different targets, both take effect in the same cycle.
- **Read:**
  - With out_en=1, at the edge src <= value(src_sel) and dst <= value(dst_sel); 1-cycle latency.
  - With out_en=0, src and dst hold their previous values.
  - value(r) is the register's next-state value for that edge (write-first bypass). A same-cycle write or adjust to r is visible in the captured output, including partial-byte merges.
  - src_sel==dst_sel is legal; both outputs show the same value.
- **ZERO_REG=1:** register 0 is constant 0.
  - Writes and adjusts to it are ignored.
  - An adjust to it drives adj_val=0 and adj_wrap=0.
  - Reads of it return 0.
- **Other rules:**
  - No internal state machine beyond the storage array.
  - All outputs are registered; there are no combinational paths from inputs to outputs.
  - Out-of-range selects cannot occur (NREGS is a power of two).

Decomposition:
- Shared CPU package holds:
  - the register-index constants (R0..R7, SP = 7);
  - a WIDTH default constant;
  - a byte-merge function (old, new, be) -> merged, reused by the memory interface.
- One sub-module is natural: regfile_adjuster, a combinational +/- STEP unit with a carry/borrow out. Instantiate it once.
- Storage and bypass muxing stay in the top module.

Test Plan:
- **Reset and zero read:** pulse rst 1 cycle; src_sel=0, dst_sel=1, out_en=1 for 1 cycle -> next cycle src=0, dst=0, adj_wrap=0.
- **Write then read:** write 10 to r2 (in_be=2'b11), then write 20 to r3; then src_sel=2, dst_sel=3, out_en=1 -> src=10, dst=20; with out_en=0 the next cycle, outputs hold 10/20.
- **Byte enable and bypass:** r4=16'h1234; in the same cycle in_en=1, dst_sel=4, in=16'hABCD, in_be=2'b01, out_en=1, src_sel=4 -> next cycle src=16'h12CD, dst=16'h12CD, and r4 holds 16'h12CD afterwards.
- **Adjust wrap:**
  - r7=0, adj_en=1, adj_sel=7, adj_dec=1 -> adj_val=16'hFFFF, adj_wrap=1 for exactly 1 cycle.
  - Then adj_dec=0 -> adj_val=0, adj_wrap=1.
  - Then adj_dec=0 again -> adj_val=1, adj_wrap=0.
- **Collision:** r5=100; in_en=1, dst_sel=5, in=7, adj_en=1, adj_sel=5 in the same cycle -> r5=7, adj_val=7, adj_wrap=0. Repeat with adj_sel=6 (r6=100) -> r5=7 and r6=101.
- **ZERO_REG=1 build:** write 55 to r0 and adjust r0 up -> reading r0 returns 0 and adj_val=0. Assert rst while in_en=1 targets r1 -> r1=0 afterwards.
